dmux_lane_deser: RTL and testbench
==================================

Name: dmux_lane_deser

Overview:
- Downstream consumer of the 1-to-4 demultiplexer: the four demux outputs are serial bit lanes, and each lane carries its own strobe.
- Each lane assembles its bits into a WIDTH-bit word and parks the word in a one-deep hold buffer.
- A round-robin arbiter merges the four lanes onto one registered valid/ready output port.
- Sits between the demux fabric and the word-level consumer logic.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- lane_bit  input  4  serial data bit per lane; lane i = demux output y[i].
- lane_valid  input  4  per-lane bit strobe; any combination may be high in a cycle.
- ovf_clr  input  1  clears all sticky overflow flags.
- out_data  output  WIDTH  assembled word.
- out_lane  output  2  source lane of out_data.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts the word.
- out_perr  output  1  parity error of the word (see Optional Feature).
- overflow  output  4  sticky per-lane word-dropped flags.

Behaviour:
- Reset: all shift registers, bit counters, hold_full flags, out_data, out_lane, out_valid, out_perr and overflow go to 0; the arbiter pointer goes to lane 0. Reset asserted mid-word discards the partial word.
- Per lane, on an edge with lane_valid[i]=1:
  - sr <= {sr[WIDTH-2:0], lane_bit[i]}, MSB first; the first bit received ends up in out_data[WIDTH-1].
  - cnt increments, wrapping at WIDTH.
- Word completion happens on the edge that samples the last bit (cnt==WIDTH-1), and cnt returns to 0.
  - If the hold buffer is empty, or is being drained on the same edge: hold <= completed word, hold_full <= 1.
  - Otherwise the word is dropped and overflow[i] <= 1. The word in hold is not overwritten.
- Output stage (single register) loads when out_valid==0 or (out_valid && out_ready).
  - It takes the first lane with hold_full, searching from the pointer upward with wrap 3->0.
  - On load: out_data, out_lane and out_valid <= 1; that lane's hold_full clears on the same edge; pointer <= granted lane + 1 (mod 4).
  - If no lane has hold_full, out_valid <= 0.
- Handshake: while out_valid=1 and out_ready=0, out_data, out_lane and out_perr hold stable. A transfer occurs on an edge with out_valid && out_ready. Back-to-back transfers run at one word per cycle.
- Latency: last bit sampled at edge k -> hold_full after k -> out_valid after edge k+1 at the earliest, if the output stage is free.
- Worst-case buffering per lane: one word in the output register plus one word in hold. The third completion while both are blocked sets overflow.
- overflow: set has priority over ovf_clr on the same edge. ovf_clr never affects data or counters.
- lane_valid on a lane during the edge its hold drains is legal; no bits are lost.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Each word is WIDTH+1 serial bits: WIDTH data bits followed by one even-parity bit.
  - The counter wraps at WIDTH+1, and the parity bit is not shifted into the data.
  - out_perr = XOR of all WIDTH+1 bits. It is registered with out_data and held under the same handshake rules.
- Not defined:
  - Words are WIDTH bits and out_perr is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Package dmux_deser_pkg holds:
  - LANES = 4 and LANE_W = 2;
  - typedef lane_idx_t (logic [LANE_W-1:0]);
  - the rr_next() helper for pointer increment with wrap.
- Sub-module dmux_lane_shift, instantiated 4 times:
  - contains one lane's shift register, counter, hold buffer, hold_full, overflow bit and parity accumulator;
  - inputs: drain strobe and ovf_clr; outputs: hold word, hold_full and overflow.
- The arbiter and output register live in the top module.

Test Plan:
1. WIDTH=8, out_ready=1; lane 2 receives 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> out_valid for exactly 1 cycle, 2 edges after the last bit, with out_data=8'hA5 and out_lane=2.
2. All four lanes complete on the same edge with 8'h11, 8'h22, 8'h33, 8'h44; out_ready=1 -> outputs on 4 consecutive cycles in lane order 0,1,2,3; the pointer ends at 0.
3. out_ready=0; lane 1 completes 8'h3C, then 8'hC3, then 8'hFF -> out_data holds 8'h3C stable, overflow[1]=1, and 8'hFF is dropped. Raising out_ready then yields 8'h3C followed by 8'hC3.
4. rst pulsed after 5 bits on lane 0, then 8 fresh bits 8'h5A -> out_data=8'h5A, with no residue from the aborted word.
5. overflow[3] already set; ovf_clr is asserted on the same edge as a new lane 3 overflow -> overflow[3] stays 1. A later ovf_clr alone -> 0.
6. DESER_PARITY_EN defined: lane 0 sends 8'hA5 plus parity bit 1 -> out_perr=1; 8'hA5 plus parity bit 0 -> out_perr=0, with out_data=8'hA5 in both cases.

Source files
------------

// File: rtl/dmux_deser_pkg.sv
// Shared lane-count constants, lane index type and round-robin helper
// for the lane deserializer.
package dmux_deser_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_idx_t;

    function automatic lane_idx_t rr_next(input lane_idx_t p);
        return (p == lane_idx_t'(LANES - 1)) ? '0 : lane_idx_t'(p + 1'b1);
    endfunction

endpackage

// File: rtl/dmux_lane_shift.sv
// One serial lane: MSB-first shift register, bit counter, one-deep hold
// buffer and sticky overflow. DESER_PARITY_EN appends an even-parity bit per word.
module dmux_lane_shift
    import dmux_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             drain,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] hold_word,
    output logic             hold_full,
    output logic             hold_perr,
    output logic             overflow
);

`ifdef DESER_PARITY_EN
    localparam int BITS = WIDTH + 1;
`else
    localparam int BITS = WIDTH;
`endif
    localparam int CW = $clog2(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             word_done;
    logic [WIDTH-1:0] done_word;
    logic             done_perr;

    assign word_done = bit_valid && (cnt == LAST);

`ifdef DESER_PARITY_EN
    logic par;

    // The trailing parity bit closes the word but is never shifted into data.
    assign done_word = sr;
    assign done_perr = par ^ bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
        end else if (bit_valid) begin
            par <= word_done ? 1'b0 : (par ^ bit_in);
        end
    end
`else
    assign done_word = {sr[WIDTH-2:0], bit_in};
    assign done_perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            hold_word <= '0;
            hold_full <= 1'b0;
            hold_perr <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (drain)
                hold_full <= 1'b0;
            if (ovf_clr)
                overflow <= 1'b0;
            if (bit_valid) begin
                if (word_done) begin
                    cnt <= '0;
                    // A hold being drained this edge counts as free.
                    if (!hold_full || drain) begin
                        hold_word <= done_word;
                        hold_perr <= done_perr;
                        hold_full <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                    sr  <= {sr[WIDTH-2:0], bit_in};
                end
            end
        end
    end

endmodule

// File: rtl/dmux_lane_deser.sv
// Four serial lanes deserialized into words and merged round-robin onto one
// registered valid/ready port. Optional parity build: DESER_PARITY_EN.
module dmux_lane_deser
    import dmux_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       lane_bit,
    input  logic [3:0]       lane_valid,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_lane,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr,
    output logic [3:0]       overflow
);

    logic [WIDTH-1:0] hold_word [LANES];
    logic [LANES-1:0] hold_full;
    logic [LANES-1:0] hold_perr;
    logic [LANES-1:0] drain;
    lane_idx_t        ptr;
    lane_idx_t        grant;
    lane_idx_t        cand;
    logic             grant_vld;
    logic             load;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dmux_lane_shift #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .bit_in    (lane_bit[i]),
            .bit_valid (lane_valid[i]),
            .drain     (drain[i]),
            .ovf_clr   (ovf_clr),
            .hold_word (hold_word[i]),
            .hold_full (hold_full[i]),
            .hold_perr (hold_perr[i]),
            .overflow  (overflow[i])
        );
    end

    assign load = !out_valid || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant     = ptr;
        cand      = ptr;
        for (int k = 0; k < LANES; k++) begin
            cand = lane_idx_t'(ptr + lane_idx_t'(k));
            if (!grant_vld && hold_full[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        drain = '0;
        if (load && grant_vld)
            drain[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_lane  <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_vld) begin
                out_data  <= hold_word[grant];
                out_lane  <= grant;
                out_perr  <= hold_perr[grant];
                out_valid <= 1'b1;
                ptr       <= rr_next(grant);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmux_lane_deser.sv
// Scoreboard bench for dmux_lane_deser: directed serial words per lane,
// expected words queued at issue and popped by an output monitor.
module tb_dmux_lane_deser;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       lane;
        logic             perr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       lane_bit;
    logic [3:0]       lane_valid;
    logic             ovf_clr;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_lane;
    logic             out_valid;
    logic             out_ready;
    logic             out_perr;
    logic [3:0]       overflow;

    exp_t sb [$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;

    dmux_lane_deser #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .lane_bit   (lane_bit),
        .lane_valid (lane_valid),
        .ovf_clr    (ovf_clr),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_perr   (out_perr),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h lane=%0d perr=%0d, expected none",
                         out_data, out_lane, out_perr);
            end else begin
                got = sb.pop_front();
                if (out_data !== got.data || out_lane !== got.lane || out_perr !== got.perr) begin
                    errors++;
                    $display("FAIL word: got data=%h lane=%0d perr=%0d, expected data=%h lane=%0d perr=%0d",
                             out_data, out_lane, out_perr, got.data, got.lane, got.perr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic [1:0] ln, input logic pb);
        exp_t e;
        e.data = d;
        e.lane = ln;
`ifdef DESER_PARITY_EN
        e.perr = (^d) ^ pb;
`else
        e.perr = 1'b0 & pb;
`endif
        sb.push_back(e);
    endtask

    // Serialize one word per selected lane, all lanes in lockstep.
    task automatic send(input logic [3:0] mask,
                        input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                        input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3,
                        input logic pb, input logic clr_last);
        logic [WIDTH-1:0] w [4];
        int nb;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
`ifdef DESER_PARITY_EN
        nb = WIDTH + 1;
`else
        nb = WIDTH;
`endif
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 4; i++)
                lane_bit[i] = (b < WIDTH) ? w[i][WIDTH-1-b] : pb;
            lane_valid = mask;
            ovf_clr    = clr_last && (b == nb - 1);
            @(posedge clk); #1;
        end
        lane_valid = '0;
        lane_bit   = '0;
        ovf_clr    = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        lane_bit   = '0;
        lane_valid = '0;
        ovf_clr    = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: lane 2 word A5, latency and single-cycle valid
        push_exp(8'hA5, 2'd2, 1'b0);
        send(4'b0100, '0, '0, 8'hA5, '0, 1'b0, 1'b0);
        chk("t1_valid_after_last", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid_next", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_lane", 32'(out_lane), 32'd2);
        @(posedge clk); #1;
        chk("t1_valid_one_cycle", 32'(out_valid), 32'd0);
        wait_drain();

        // 2: all lanes complete together, pointer starts at 0
        do_reset();
        push_exp(8'h11, 2'd0, 1'b0);
        push_exp(8'h22, 2'd1, 1'b0);
        push_exp(8'h33, 2'd2, 1'b0);
        push_exp(8'h44, 2'd3, 1'b0);
        send(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
        wait_drain();
        // Pointer back at 0: lane 0 must win over lane 1.
        push_exp(8'h81, 2'd0, 1'b0);
        push_exp(8'h18, 2'd1, 1'b0);
        send(4'b0011, 8'h81, 8'h18, '0, '0, 1'b0, 1'b0);
        wait_drain();
        @(posedge clk); #1;
        chk("t2_idle", 32'(out_valid), 32'd0);

        // 3: backpressure on lane 1, third word dropped
        out_ready = 1'b0;
        push_exp(8'h3C, 2'd1, 1'b0);
        send(4'b0010, '0, 8'h3C, '0, '0, 1'b0, 1'b0);
        push_exp(8'hC3, 2'd1, 1'b0);
        send(4'b0010, '0, 8'hC3, '0, '0, 1'b0, 1'b0);
        chk("t3_hold_valid", 32'(out_valid), 32'd1);
        chk("t3_hold_data1", 32'(out_data), 32'h3C);
        chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
        send(4'b0010, '0, 8'hFF, '0, '0, 1'b0, 1'b0);
        chk("t3_hold_data2", 32'(out_data), 32'h3C);
        chk("t3_hold_lane", 32'(out_lane), 32'd1);
        chk("t3_overflow", 32'(overflow), 32'b0010);
        out_ready = 1'b1;
        wait_drain();
        @(posedge clk); #1;
        chk("t3_ff_dropped", 32'(out_valid), 32'd0);

        // 4: reset mid-word discards the partial word
        for (int b = 0; b < 5; b++) begin
            lane_valid = 4'b0001;
            lane_bit   = 4'b0001;
            @(posedge clk); #1;
        end
        lane_valid = '0;
        lane_bit   = '0;
        do_reset();
        chk("t4_ovf_cleared", 32'(overflow), 32'd0);
        push_exp(8'h5A, 2'd0, 1'b0);
        send(4'b0001, 8'h5A, '0, '0, '0, 1'b0, 1'b0);
        wait_drain();

        // 5: overflow set beats ovf_clr on the same edge
        out_ready = 1'b0;
        push_exp(8'h01, 2'd3, 1'b0);
        push_exp(8'h02, 2'd3, 1'b0);
        send(4'b1000, '0, '0, '0, 8'h01, 1'b0, 1'b0);
        send(4'b1000, '0, '0, '0, 8'h02, 1'b0, 1'b0);
        send(4'b1000, '0, '0, '0, 8'h03, 1'b0, 1'b0);
        chk("t5_ovf_set", 32'(overflow), 32'b1000);
        send(4'b1000, '0, '0, '0, 8'h04, 1'b0, 1'b1);
        chk("t5_set_beats_clr", 32'(overflow), 32'b1000);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("t5_clr_alone", 32'(overflow), 32'd0);
        chk("t5_data_untouched", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        wait_drain();

`ifdef DESER_PARITY_EN
        // 6: parity bit checked and excluded from data
        push_exp(8'hA5, 2'd0, 1'b1);
        send(4'b0001, 8'hA5, '0, '0, '0, 1'b1, 1'b0);
        wait_drain();
        push_exp(8'hA5, 2'd0, 1'b0);
        send(4'b0001, 8'hA5, '0, '0, '0, 1'b0, 1'b0);
        wait_drain();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", 32'(out_valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
